// File: rtl/main_mem_model.sv
// Line-granular backing memory behind the cache memory port, fixed access latency.
// Optional MEM_STATS_EN adds saturating read/write completion counters.
module main_mem_model #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_dataout,
    input  logic              mem_req_rw,
    input  logic              mem_req_valid,
    output logic [DATA_W-1:0] mem_req_datain,
    output logic              mem_req_ready
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]       stat_rd_cnt,
    output logic [15:0]       stat_wr_cnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] datain_q, datain_d;
    logic              done;

    // The array has no reset; contents survive rst_n.
    logic [DATA_W-1:0] mem_array [DEPTH];

    // Offset nibble and aliasing upper bits are intentionally dropped.
    logic addr_unused;
    assign addr_unused = ^{mem_req_addr[ADDR_W-1:4+IDX_W], mem_req_addr[3:0]};

    assign done = (state_q == BUSY) && (cnt_q == 8'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rw_d     = rw_q;
        wdata_d  = wdata_q;
        datain_d = datain_q;
        unique case (state_q)
            IDLE: begin
                if (mem_req_valid) begin
                    state_d = BUSY;
                    cnt_d   = LAT_M1;
                    idx_d   = mem_req_addr[4 +: IDX_W];
                    rw_d    = mem_req_rw;
                    wdata_d = mem_req_dataout;
                end
            end
            BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    if (!rw_q) datain_d = mem_array[idx_q];
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (!mem_req_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= '0;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
            datain_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            rw_q     <= rw_d;
            wdata_q  <= wdata_d;
            datain_q <= datain_d;
        end
    end

    // A reset mid-access forces IDLE asynchronously, so no commit can follow.
    always_ff @(posedge clk) begin
        if (done && rw_q) mem_array[idx_q] <= wdata_q;
    end

    assign mem_req_datain = datain_q;
    assign mem_req_ready  = (state_q != BUSY);

`ifdef MEM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (done && !rw_q && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        if (done && rw_q && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign stat_rd_cnt = rd_cnt_q;
    assign stat_wr_cnt = wr_cnt_q;
`endif

endmodule
